// File: rtl/qc_enc_pkg.sv
// Shared types and constants for the QC-LDPC encoder scheduler.
package qc_enc_pkg;

  localparam int K_INFO = 27;
  localparam int N_PAR  = 162;

  typedef logic [K_INFO-1:0] info_t;
  typedef logic [N_PAR-1:0]  par_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/qc_encode_sched_chk.sv
// Checker for the scheduler: a FIFO push must never land on a full buffer.
module qc_encode_sched_chk #(
  parameter  int OUT_DEPTH = 8,
  localparam int CW        = $clog2(OUT_DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] occ
);

  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (occ < CW'(OUT_DEPTH)));

endmodule

// File: rtl/qc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, when enabled.
module qc_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic          found_s;
  logic [IW-1:0] cand_s;
  logic [IW-1:0] sel_s;

  // Wrapping priority search starting at ptr
  always_comb begin
    found_s = 1'b0;
    cand_s  = '0;
    sel_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = IW'((int'(ptr) + k) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant outputs gated by the enable
  always_comb begin
    gnt     = '0;
    any     = found_s & en;
    gnt_idx = sel_s;
    if (any) begin
      gnt[sel_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/qc_encode_sched.sv
// Round-robin scheduler sharing one fixed-latency parity encoder between N_REQ requesters,
// with credit-based issue into a tagged first-word-fall-through output FIFO and a flush FSM.
module qc_encode_sched
  import qc_enc_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int ENC_LAT   = 3,
  parameter  int OUT_DEPTH = 8,
  localparam int IW        = $clog2(N_REQ),
  localparam int CW        = $clog2(OUT_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*K_INFO-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    enc_valid,
  output info_t                   enc_data,
  input  par_t                    enc_parity,
  output logic                    out_valid,
  input  logic                    out_ready,
  output par_t                    out_data,
  output logic [IW-1:0]           out_id,
  input  logic                    flush,
  output logic                    flush_done
);

  localparam int PW  = $clog2(OUT_DEPTH);
  // Entry 0 lines up with enc_valid, the last entry with the cycle enc_parity is sampled.
  localparam int NST = ENC_LAT + 1;

  sched_state_e   state_r, state_s;
  logic [IW-1:0]  rr_ptr_r;
  info_t          enc_data_r;
  logic [NST-1:0] tag_vld_r;
  logic [IW-1:0]  tag_id_r [NST];

  logic [CW-1:0]  occ_r, infl_s;
  logic           credit_s, grant_en_s, gnt_any_s;
  logic [N_REQ-1:0] gnt_s;
  logic [IW-1:0]  gnt_idx_s;

  par_t           fifo_par_r [OUT_DEPTH];
  logic [IW-1:0]  fifo_id_r  [OUT_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic           push_s, pop_s;

  // In-flight count: every valid tag holds one reserved FIFO slot
  always_comb begin
    infl_s = '0;
    for (int i = 0; i < NST; i++) begin
      infl_s = infl_s + CW'(tag_vld_r[i]);
    end
  end

  assign credit_s   = ({1'b0, occ_r} + {1'b0, infl_s}) < (CW+1)'(OUT_DEPTH);
  assign grant_en_s = !rst && (state_r == RUN) && !flush && credit_s;

  qc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .en      (grant_en_s),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (gnt_any_s)
  );

  assign req_ready = gnt_s;
  assign enc_valid = tag_vld_r[0];
  assign enc_data  = enc_data_r;

  // Issue register, round-robin pointer and tag pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r   <= '0;
      enc_data_r <= '0;
      tag_vld_r  <= '0;
      for (int i = 0; i < NST; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_vld_r   <= {tag_vld_r[NST-2:0], gnt_any_s};
      tag_id_r[0] <= gnt_idx_s;
      for (int i = 1; i < NST; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
      if (gnt_any_s) begin
        rr_ptr_r   <= (gnt_idx_s == IW'(N_REQ-1)) ? '0 : gnt_idx_s + IW'(1);
        enc_data_r <= req_data[K_INFO*gnt_idx_s +: K_INFO];
      end
    end
  end

  assign push_s    = tag_vld_r[NST-1];
  assign out_valid = (occ_r != '0);
  assign pop_s     = out_valid & out_ready;

  // FIFO storage, written when the tagged parity word emerges from the encoder
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_par_r[wr_ptr_r] <= enc_parity;
      fifo_id_r[wr_ptr_r]  <= tag_id_r[NST-1];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PW'(push_s);
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Head of FIFO; forced to zero while empty so nothing stale is visible
  always_comb begin
    out_data = '0;
    out_id   = '0;
    if (out_valid) begin
      out_data = fifo_par_r[rd_ptr_r];
      out_id   = fifo_id_r[rd_ptr_r];
    end else begin
      out_data = '0;
      out_id   = '0;
    end
  end

  // Flush FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Flush FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN: begin
        if (flush) state_s = DRAIN;
        else       state_s = RUN;
      end
      DRAIN: begin
        if ((infl_s == '0) && (occ_r == '0)) state_s = DONE;
        else                                 state_s = DRAIN;
      end
      DONE: begin
        if (!flush) state_s = RUN;
        else        state_s = DONE;
      end
      default: state_s = RUN;
    endcase
  end

  assign flush_done = (state_r == DONE);

  qc_encode_sched_chk #(.OUT_DEPTH(OUT_DEPTH)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .occ  (occ_r)
  );

endmodule

// File: tb/tb_qc_encode_sched.sv
// Self-checking bench for qc_encode_sched: behavioural encoder model plus an in-order scoreboard.
module tb_qc_encode_sched;

  localparam int ENC_LAT = 3;

  logic         clk, rst;
  logic [3:0]   req_valid, req_ready;
  logic [107:0] req_data;
  logic         enc_valid;
  logic [26:0]  enc_data;
  logic [161:0] enc_parity;
  logic         out_valid, out_ready;
  logic [161:0] out_data;
  logic [1:0]   out_id;
  logic         flush, flush_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int           id;
    logic [161:0] par;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e_m, e_p;
  int           gnt_log[$];
  int           gnt_cyc_log[$];
  int           pop_id_log[$];
  int           pop_cyc_log[$];
  logic [161:0] pop_data_log[$];
  logic [26:0]  enc_pipe [ENC_LAT];

  qc_encode_sched #(.N_REQ(4), .ENC_LAT(ENC_LAT), .OUT_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .enc_valid  (enc_valid),
    .enc_data   (enc_data),
    .enc_parity (enc_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .flush      (flush),
    .flush_done (flush_done)
  );

  // Reference parity: six rotated/XORed circulant blocks of the info word
  function automatic logic [161:0] enc_fn(input logic [26:0] u);
    logic [161:0] p;
    logic [26:0]  a, b;
    int           r1, r2;
    p = '0;
    for (int k = 0; k < 6; k++) begin
      r1 = (5*k + 1) % 27;
      r2 = (7*k + 3) % 27;
      a  = (u << r1) | (u >> (27 - r1));
      b  = (u << r2) | (u >> (27 - r2));
      p[27*k +: 27] = a ^ b ^ {26'd0, ^u};
    end
    return p;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Encoder model: captures enc_data the edge after issue, result ENC_LAT cycles after enc_valid
  always @(posedge clk) begin
    enc_pipe[0] <= enc_data;
    for (int k = 1; k < ENC_LAT; k++) enc_pipe[k] <= enc_pipe[k-1];
  end
  assign enc_parity = enc_fn(enc_pipe[ENC_LAT-1]);

  // Monitor just before each rising edge: scoreboard pops, one-hot grant, scoreboard pushes
  always @(negedge clk) begin
    #4;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id %0d data %h, want no output", out_id, out_data);
        end else begin
          e_p = sb.pop_front();
          if (int'(out_id) !== e_p.id || out_data !== e_p.par) begin
            n_fail++;
            $display("FAIL sb_data: got id %0d data %h, want id %0d data %h",
                     out_id, out_data, e_p.id, e_p.par);
          end
        end
        pop_id_log.push_back(int'(out_id));
        pop_cyc_log.push_back(cyc);
        pop_data_log.push_back(out_data);
      end
      n_tests++;
      if ($countones(req_ready) > 1) begin
        n_fail++;
        $display("FAIL ready_onehot: got %b, want at most one bit", req_ready);
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e_m.id  = i;
          e_m.par = enc_fn(req_data[27*i +: 27]);
          e_m.cyc = cyc;
          sb.push_back(e_m);
          gnt_log.push_back(i);
          gnt_cyc_log.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc_log.delete();
    pop_id_log.delete();
    pop_cyc_log.delete();
    pop_data_log.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) req_data[27*i +: 27] = 27'($urandom);
  endtask

  task automatic test_reset();
    int stale;
    rst = 1'b1; req_valid = 4'b0000; req_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, enc_valid, enc_data, out_valid, out_data, out_id, flush_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy %b ev %b ed %h ov %b oid %0d fd %b, want all 0",
               req_ready, enc_valid, enc_data, out_valid, out_id, flush_done);
    end
    rst = 1'b0;
    clear_logs();
    req_valid = 4'b1111;
    rand_data();
    repeat (3) @(negedge clk);
    n_tests++;
    if (gnt_log.size() != 3 || enc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_issue: got %0d grants ev %b, want 3 grants ev 1", gnt_log.size(), enc_valid);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL ready_in_reset: got %b, want 0000", req_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({enc_valid, enc_data, out_valid, out_data, out_id, flush_done} !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset: got ev %b ed %h ov %b oid %0d fd %b, want all 0",
               enc_valid, enc_data, out_valid, out_id, flush_done);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant_after_reset: got %b, want 0001", req_ready);
    end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL stale_after_reset: got %0d valid cycles, want 0", stale);
    end
  endtask

  task automatic test_round_robin();
    clear_logs();
    out_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (16) begin
      rand_data();
      @(negedge clk);
    end
    req_valid = 4'b0000;
    repeat (12) @(negedge clk);
    n_tests++;
    if (gnt_log.size() != 16 || pop_id_log.size() != 16) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants %0d outputs, want 16 16", gnt_log.size(), pop_id_log.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_tests++;
        if (gnt_log[k] !== k % 4 || pop_id_log[k] !== k % 4) begin
          n_fail++;
          $display("FAIL rr_seq[%0d]: got grant %0d out_id %0d, want %0d", k, gnt_log[k], pop_id_log[k], k % 4);
        end
        if (k > 0) begin
          n_tests++;
          if (gnt_cyc_log[k] - gnt_cyc_log[k-1] != 1 || pop_cyc_log[k] - pop_cyc_log[k-1] != 1) begin
            n_fail++;
            $display("FAIL rr_bubble[%0d]: got grant gap %0d out gap %0d, want 1 1", k,
                     gnt_cyc_log[k] - gnt_cyc_log[k-1], pop_cyc_log[k] - pop_cyc_log[k-1]);
          end
        end
      end
      n_tests++;
      if (pop_cyc_log[0] - gnt_cyc_log[0] != ENC_LAT + 2) begin
        n_fail++;
        $display("FAIL rr_latency: got %0d, want %0d", pop_cyc_log[0] - gnt_cyc_log[0], ENC_LAT + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (12) begin
      rand_data();
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (gnt_log.size() != 8 || req_ready !== 4'b0000 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_stop: got %0d grants rdy %b ov %b, want 8 0000 1", gnt_log.size(), req_ready, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (gnt_log.size() != 9) begin
      n_fail++;
      $display("FAIL credit_one_more: got %0d grants, want 9", gnt_log.size());
    end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (sb.size() != 0 || pop_id_log.size() != 9) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pending %0d outputs, want 0 9", sb.size(), pop_id_log.size());
    end
  endtask

  task automatic test_single();
    logic [26:0]  u;
    logic [161:0] want;
    clear_logs();
    u = 27'h5A5A5A3;
    want = enc_fn(u);
    out_ready = 1'b1;
    req_data = '0;
    req_data[54 +: 27] = u;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (10) @(negedge clk);
    n_tests++;
    if (pop_id_log.size() != 1 || gnt_log.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d outputs %0d grants, want 1 1", pop_id_log.size(), gnt_log.size());
    end else begin
      n_tests++;
      if (pop_id_log[0] !== 2 || pop_data_log[0] !== want) begin
        n_fail++;
        $display("FAIL single_word: got id %0d data %h, want id 2 data %h", pop_id_log[0], pop_data_log[0], want);
      end
      n_tests++;
      if (pop_cyc_log[0] - gnt_cyc_log[0] != ENC_LAT + 2) begin
        n_fail++;
        $display("FAIL single_latency: got %0d, want %0d", pop_cyc_log[0] - gnt_cyc_log[0], ENC_LAT + 2);
      end
    end
  endtask

  task automatic test_flush();
    int done, leak;
    clear_logs();
    out_ready = 1'b0;
    req_valid = 4'b1110;
    repeat (5) begin
      rand_data();
      @(negedge clk);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_first_cycle: got rdy %b ov %b, want 0000 1", req_ready, out_valid);
    end
    n_tests++;
    if (gnt_log.size() != 5 || gnt_log[0] !== 3 || gnt_log[1] !== 1 || gnt_log[2] !== 2 ||
        gnt_log[3] !== 3 || gnt_log[4] !== 1) begin
      n_fail++;
      $display("FAIL flush_pre_grants: got %0d grants, want sequence 3,1,2,3,1", gnt_log.size());
    end
    done = 0;
    leak = 0;
    for (int c = 0; c < 40 && done == 0; c++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) leak++;
      if (flush_done === 1'b1) done = 1;
    end
    n_tests++;
    if (done != 1) begin
      n_fail++;
      $display("FAIL flush_timeout: got flush_done 0 after 40 cycles, want 1");
    end
    n_tests++;
    if (leak != 0 || gnt_log.size() != 5) begin
      n_fail++;
      $display("FAIL flush_grant_leak: got %0d ready cycles %0d grants, want 0 5", leak, gnt_log.size());
    end
    n_tests++;
    if (pop_id_log.size() != 5 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drain: got %0d outputs %0d pending, want 5 0", pop_id_log.size(), sb.size());
    end
    flush = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000 || flush_done !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_hold: got rdy %b fd %b, want 0000 1", req_ready, flush_done);
    end
    @(negedge clk);
    n_tests++;
    if (flush_done !== 1'b0 || req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL flush_resume: got fd %b rdy %b, want 0 0100", flush_done, req_ready);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_skip();
    int busy;
    clear_logs();
    out_ready = 1'b1;
    rand_data();
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) busy++;
    end
    n_tests++;
    if (busy != 0) begin
      n_fail++;
      $display("FAIL idle_ready: got %0d busy cycles, want 0", busy);
    end
    req_valid = 4'b1111;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL idle_keeps_ptr: got %b, want 0010", req_ready);
    end
    req_valid = 4'b1101;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL skip_dropped: got %b, want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (10) @(negedge clk);
    n_tests++;
    if (gnt_log.size() != 2 || gnt_log[0] !== 0 || gnt_log[1] !== 2 || sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_final: got %0d grants %0d pending ov %b, want grants 0,2 none pending ov 0",
               gnt_log.size(), sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single();
    test_flush();
    test_skip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000ns, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
